// File: rtl/tl_lamp_drv.sv
// Lamp driver behind the traffic-light phase FSM: start-up flashing, all-red
// clearance, pedestrian walk pulses (macro TLDRV_WALK_EN) and sticky fault.
module tl_lamp_drv #(
  parameter int CNT_WIDTH     = 8,
  parameter int BLINK_DIV     = 4,
  parameter int ALLRED_CYCLES = 2,
  parameter int WALK_CYCLES   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_state,
  output logic [2:0] o_ns_lamp,
  output logic [2:0] o_ew_lamp,
  output logic       o_ns_walk,
  output logic       o_ew_walk,
  output logic       o_fault
);

  localparam logic [2:0] ST_START = 3'b111;
  localparam logic [2:0] ST_NS    = 3'b011;
  localparam logic [2:0] ST_NY    = 3'b010;
  localparam logic [2:0] ST_EW    = 3'b000;
  localparam logic [2:0] ST_EY    = 3'b001;

  localparam logic [1:0] M_FLASH = 2'd0;
  localparam logic [1:0] M_CLEAR = 2'd1;
  localparam logic [1:0] M_RUN   = 2'd2;
  localparam logic [1:0] M_FAULT = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] BLINK_LAST = CNT_WIDTH'((BLINK_DIV > 0) ? BLINK_DIV - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] CLR_LOAD   = CNT_WIDTH'((ALLRED_CYCLES > 0) ? ALLRED_CYCLES - 1 : 0);

  logic [1:0]           mode, mode_n;
  logic [2:0]           prev, prev_n;
  logic [CNT_WIDTH-1:0] blink_cnt, blink_n;
  logic                 phase, phase_n;
  logic [CNT_WIDTH-1:0] clr_cnt, clr_n;
  logic                 to_green;
  logic [2:0]           ns_lamp_n, ew_lamp_n;
  logic                 fault_n;

  function automatic logic legal_move(input logic [2:0] p, input logic [2:0] c);
    logic known;
    known = (c == ST_START) || (c == ST_NS) || (c == ST_NY) ||
            (c == ST_EW) || (c == ST_EY);
    return known && ((c == p) || (c == ST_START) ||
                     (p == ST_START && c == ST_NS) || (p == ST_NS && c == ST_NY) ||
                     (p == ST_NY && c == ST_EW) || (p == ST_EW && c == ST_EY) ||
                     (p == ST_EY && c == ST_NS));
  endfunction

  always_comb begin
    blink_n = blink_cnt + CNT_ONE;
    phase_n = phase;
    if (blink_cnt >= BLINK_LAST) begin
      blink_n = '0;
      phase_n = ~phase;
    end
  end

  // Illegal input is checked first so it wins over clearance expiry.
  always_comb begin
    mode_n   = mode;
    prev_n   = prev;
    clr_n    = clr_cnt;
    to_green = 1'b0;
    if (mode != M_FAULT) begin
      if (!legal_move(prev, i_state)) begin
        mode_n = M_FAULT;
      end else begin
        prev_n = i_state;
        case (mode)
          M_FLASH: begin
            if (i_state == ST_NS) to_green = 1'b1;
          end
          M_CLEAR: begin
            if (i_state == prev) begin
              if (clr_cnt == '0) mode_n = M_RUN;
              else               clr_n = clr_cnt - CNT_ONE;
            end else if (i_state == ST_START) begin
              mode_n = M_FLASH;
            end else begin
              mode_n = M_RUN;
            end
          end
          default: begin
            if (i_state != prev) begin
              if (i_state == ST_START)                          mode_n = M_FLASH;
              else if (i_state == ST_NS || i_state == ST_EW)    to_green = 1'b1;
            end
          end
        endcase
        if (to_green) begin
          if (ALLRED_CYCLES == 0) begin
            mode_n = M_RUN;
          end else begin
            mode_n = M_CLEAR;
            clr_n  = CLR_LOAD;
          end
        end
      end
    end
  end

  always_comb begin
    ns_lamp_n = 3'b100;
    ew_lamp_n = 3'b100;
    fault_n   = 1'b0;
    case (mode_n)
      M_FLASH: begin
        ns_lamp_n = {1'b0, phase_n, 1'b0};
        ew_lamp_n = {1'b0, phase_n, 1'b0};
      end
      M_RUN: begin
        case (prev_n)
          ST_NS:   ns_lamp_n = 3'b001;
          ST_NY:   ns_lamp_n = 3'b010;
          ST_EW:   ew_lamp_n = 3'b001;
          ST_EY:   ew_lamp_n = 3'b010;
          default: ;
        endcase
      end
      M_FAULT: begin
        ns_lamp_n = {phase_n, 2'b00};
        ew_lamp_n = {phase_n, 2'b00};
        fault_n   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode      <= M_FLASH;
      prev      <= ST_START;
      blink_cnt <= '0;
      phase     <= 1'b0;
      clr_cnt   <= '0;
      o_ns_lamp <= 3'b000;
      o_ew_lamp <= 3'b000;
      o_fault   <= 1'b0;
    end else begin
      mode      <= mode_n;
      prev      <= prev_n;
      blink_cnt <= blink_n;
      phase     <= phase_n;
      clr_cnt   <= clr_n;
      o_ns_lamp <= ns_lamp_n;
      o_ew_lamp <= ew_lamp_n;
      o_fault   <= fault_n;
    end
  end

`ifdef TLDRV_WALK_EN
  localparam logic [CNT_WIDTH-1:0] WALK_LOAD = CNT_WIDTH'(WALK_CYCLES);

  logic [CNT_WIDTH-1:0] walk_cnt, walk_n;
  logic                 ns_walk_n, ew_walk_n;

  // The count only survives while the same green is held in RUN, so any
  // end of green (yellow, START, fault) clears the walk on that very edge.
  always_comb begin
    walk_n = '0;
    if (mode_n == M_RUN && (prev_n == ST_NS || prev_n == ST_EW)) begin
      if (!(mode == M_RUN && prev == prev_n)) walk_n = WALK_LOAD;
      else if (walk_cnt != '0)                walk_n = walk_cnt - CNT_ONE;
    end
    ns_walk_n = (walk_n != '0) && (prev_n == ST_NS);
    ew_walk_n = (walk_n != '0) && (prev_n == ST_EW);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      walk_cnt  <= '0;
      o_ns_walk <= 1'b0;
      o_ew_walk <= 1'b0;
    end else begin
      walk_cnt  <= walk_n;
      o_ns_walk <= ns_walk_n;
      o_ew_walk <= ew_walk_n;
    end
  end
`else
  assign o_ns_walk = 1'b0;
  assign o_ew_walk = 1'b0;
`endif

endmodule

// File: tb/tb_tl_lamp_drv.sv
// Scoreboard bench for tl_lamp_drv: directed phase codes with hand-written
// expected lamps; walk expectations collapse to 0 without TLDRV_WALK_EN.
module tb_tl_lamp_drv;

  localparam logic [2:0] ST_START = 3'b111;
  localparam logic [2:0] ST_NS    = 3'b011;
  localparam logic [2:0] ST_NY    = 3'b010;
  localparam logic [2:0] ST_EW    = 3'b000;
  localparam logic [2:0] ST_EY    = 3'b001;
  localparam logic [2:0] L_R      = 3'b100;
  localparam logic [2:0] L_Y      = 3'b010;
  localparam logic [2:0] L_G      = 3'b001;

  logic       i_clk;
  logic       i_rst_n;
  logic [2:0] i_state;
  logic [2:0] o_ns_lamp, o_ew_lamp;
  logic       o_ns_walk, o_ew_walk, o_fault;

  typedef struct {
    int         step;
    logic [8:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;
  int   step   = 0;

  tl_lamp_drv dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_state   (i_state),
    .o_ns_lamp (o_ns_lamp),
    .o_ew_lamp (o_ew_lamp),
    .o_ns_walk (o_ns_walk),
    .o_ew_walk (o_ew_walk),
    .o_fault   (o_fault)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [8:0] outVec();
    return {o_ns_lamp, o_ew_lamp, o_ns_walk, o_ew_walk, o_fault};
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got ns=%b ew=%b walk=%b%b fault=%b, expected ns=%b ew=%b walk=%b%b fault=%b",
               name, act[8:6], act[5:3], act[2], act[1], act[0],
               expv[8:6], expv[5:3], expv[2], expv[1], expv[0]);
    end
  endtask

  // Entered at a falling edge; the code is sampled at the next rising edge.
  task automatic applyStimulus(input logic [2:0] s, input logic [2:0] ns, input logic [2:0] ew,
                               input logic nsw, input logic eww, input logic flt);
    exp_t e;
`ifndef TLDRV_WALK_EN
    nsw = 1'b0;
    eww = 1'b0;
`endif
    i_state = s;
    edges++;
    step++;
    e.step = step;
    e.val  = {ns, ew, nsw, eww, flt};
    exp_q.push_back(e);
    @(negedge i_clk);
  endtask

  function automatic logic nextPhase();
    return (((edges + 1) / 4) % 2) == 1;
  endfunction

  task automatic applyFlash(input logic [2:0] s);
    logic ph;
    ph = nextPhase();
    applyStimulus(s, {1'b0, ph, 1'b0}, {1'b0, ph, 1'b0}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic applyFault(input logic [2:0] s);
    logic ph;
    ph = nextPhase();
    applyStimulus(s, {ph, 2'b00}, {ph, 2'b00}, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic doReset();
    i_rst_n = 1'b0;
    i_state = ST_START;
    #1;
    checkOutput("reset", outVec(), 9'b0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    edges = 0;
  endtask

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput($sformatf("step%0d", mon_e.step), outVec(), mon_e.val);
      end
    end
  end

  initial begin
    i_rst_n = 1'b0;
    i_state = ST_START;
    @(negedge i_clk);
    doReset();

    // Start-up flashing yellow.
    for (int i = 0; i < 16; i++) applyFlash(ST_START);

    // Full cycle with clearance before each green.
    repeat (2) applyStimulus(ST_NS, L_R, L_R, 1'b0, 1'b0, 1'b0);
    repeat (4) applyStimulus(ST_NS, L_G, L_R, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(ST_NS, L_G, L_R, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(ST_NY, L_Y, L_R, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(ST_EW, L_R, L_R, 1'b0, 1'b0, 1'b0);
    repeat (4) applyStimulus(ST_EW, L_R, L_G, 1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(ST_EY, L_R, L_Y, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(ST_NS, L_R, L_R, 1'b0, 1'b0, 1'b0);
    // Short green: walk cut off on the yellow edge.
    repeat (2) applyStimulus(ST_NS, L_G, L_R, 1'b1, 1'b0, 1'b0);
    applyStimulus(ST_NY, L_Y, L_R, 1'b0, 1'b0, 1'b0);
    repeat (2) applyFlash(ST_START);

    // Illegal code landing on the clearance-expiry edge.
    repeat (2) applyStimulus(ST_NS, L_R, L_R, 1'b0, 1'b0, 1'b0);
    applyFault(3'b101);
    applyFault(ST_NS);
    for (int i = 0; i < 6; i++) applyFault(ST_START);

    doReset();
    applyFlash(ST_START);
    applyStimulus(ST_NS, L_R, L_R, 1'b0, 1'b0, 1'b0);
    applyStimulus(ST_NY, L_Y, L_R, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(ST_EW, L_R, L_R, 1'b0, 1'b0, 1'b0);
    applyStimulus(ST_EW, L_R, L_G, 1'b0, 1'b1, 1'b0);
    applyStimulus(ST_EY, L_R, L_Y, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(ST_NS, L_R, L_R, 1'b0, 1'b0, 1'b0);
    applyStimulus(ST_NS, L_G, L_R, 1'b1, 1'b0, 1'b0);
    // NS green straight to EW green is an illegal sequence.
    applyFault(ST_EW);
    applyFault(ST_EY);
    applyFault(ST_NS);
    for (int i = 0; i < 4; i++) applyFault(ST_START);

    doReset();
    applyFlash(ST_START);

    @(posedge i_clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
